// File: rtl/option_sched.sv
// Option packet scheduler: buffers parsed packets in a FIFO, dispatches them round-robin
// to pricing engines and returns tagged results round-robin to a ready/valid sink.
module option_sched #(
    parameter int NUM_ENG    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [199:0]          in_pkt,
    output logic [NUM_ENG-1:0]    eng_start,
    output logic [167:0]          eng_pkt,
    input  logic [NUM_ENG-1:0]    eng_done,
    input  logic [32*NUM_ENG-1:0] eng_price,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_id,
    output logic [31:0]           res_price,
    output logic                  overflow,
    output logic [7:0]            drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    typedef enum logic [1:0] {FREE = 2'd0, RUN = 2'd1, HOLD = 2'd2} eng_st_t;

    eng_st_t            r_st     [NUM_ENG];
    eng_st_t            w_st_nxt [NUM_ENG];
    logic [31:0]        r_tag    [NUM_ENG];
    logic [31:0]        r_price  [NUM_ENG];
    logic [199:0]       r_mem    [FIFO_DEPTH];
    logic [AW:0]        r_wptr;
    logic [AW:0]        r_rptr;
    logic [EW-1:0]      r_dp;
    logic [EW-1:0]      r_rp;
    logic [EW-1:0]      r_res_eng;
    logic [NUM_ENG-1:0] r_eng_start;
    logic [167:0]       r_eng_pkt;
    logic               r_res_valid;
    logic [31:0]        r_res_id;
    logic [31:0]        r_res_price;
    logic               r_overflow;
    logic [7:0]         r_drop_cnt;

    logic [AW:0]        w_cnt;
    logic               w_empty;
    logic               w_full;
    logic               w_disp;
    logic               w_push;
    logic               w_drop;
    logic               w_acc;
    logic               w_load;
    logic [EW-1:0]      w_disp_idx;
    logic [EW-1:0]      w_sel_idx;
    logic [EW-1:0]      w_rp_nxt;
    logic [EW-1:0]      w_arb_ptr;
    logic [199:0]       w_head;

    assign w_cnt   = r_wptr - r_rptr;
    assign w_empty = (w_cnt == '0);
    assign w_full  = (w_cnt == (AW+1)'(FIFO_DEPTH));
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    // First FREE engine at or after the dispatch pointer takes the FIFO head.
    always_comb begin
        w_disp     = 1'b0;
        w_disp_idx = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (!w_disp && !w_empty && r_st[(int'(r_dp) + k) % NUM_ENG] == FREE) begin
                w_disp     = 1'b1;
                w_disp_idx = EW'((int'(r_dp) + k) % NUM_ENG);
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push    = in_valid && (!w_full || w_disp);
    assign w_drop    = in_valid && !w_push;
    assign w_acc     = r_res_valid && res_ready;
    assign w_rp_nxt  = EW'((int'(r_res_eng) + 1) % NUM_ENG);
    assign w_arb_ptr = w_acc ? w_rp_nxt : r_rp;

    // The engine currently presented is excluded so an accept can hand over in one cycle.
    always_comb begin
        w_load    = 1'b0;
        w_sel_idx = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (!w_load && (!r_res_valid || w_acc)
                && r_st[(int'(w_arb_ptr) + k) % NUM_ENG] == HOLD
                && !(r_res_valid && int'(r_res_eng) == (int'(w_arb_ptr) + k) % NUM_ENG)) begin
                w_load    = 1'b1;
                w_sel_idx = EW'((int'(w_arb_ptr) + k) % NUM_ENG);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENG; i++) begin
            w_st_nxt[i] = r_st[i];
            case (r_st[i])
                FREE:    if (w_disp && int'(w_disp_idx) == i) w_st_nxt[i] = RUN;
                RUN:     if (eng_done[i]) w_st_nxt[i] = HOLD;
                HOLD:    if (w_acc && int'(r_res_eng) == i) w_st_nxt[i] = FREE;
                default: w_st_nxt[i] = FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENG; i++) r_st[i] <= FREE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_dp        <= '0;
            r_rp        <= '0;
            r_res_eng   <= '0;
            r_eng_start <= '0;
            r_eng_pkt   <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_price <= '0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            for (int i = 0; i < NUM_ENG; i++) r_st[i] <= w_st_nxt[i];
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_disp) begin
                r_rptr    <= r_rptr + 1'b1;
                r_dp      <= EW'((int'(w_disp_idx) + 1) % NUM_ENG);
                r_eng_pkt <= w_head[167:0];
            end
            r_eng_start <= w_disp ? (NUM_ENG'(1) << w_disp_idx) : '0;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_acc) r_rp <= w_rp_nxt;
            if (w_load) begin
                r_res_valid <= 1'b1;
                r_res_eng   <= w_sel_idx;
                r_res_id    <= r_tag[w_sel_idx];
                r_res_price <= r_price[w_sel_idx];
            end else if (w_acc) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    // Packet storage, tags and captured prices need no reset: guarded by FIFO pointers and engine state.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= in_pkt;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (w_disp && int'(w_disp_idx) == i) r_tag[i] <= w_head[199:168];
            if (r_st[i] == RUN && eng_done[i]) r_price[i] <= eng_price[32*i +: 32];
        end
    end

    assign eng_start = r_eng_start;
    assign eng_pkt   = r_eng_pkt;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_price = r_res_price;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_option_sched.sv
// Scenario bench for option_sched with two engines: the bench plays the engines and the
// result sink, and checks dispatch and results against queues of expected values.
module tb_option_sched;
    localparam int NE = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [199:0]    in_pkt;
    logic [NE-1:0]   eng_start;
    logic [167:0]    eng_pkt;
    logic [NE-1:0]   eng_done;
    logic [32*NE-1:0] eng_price;
    logic            res_valid;
    logic            res_ready;
    logic [31:0]     res_id;
    logic [31:0]     res_price;
    logic            overflow;
    logic [7:0]      drop_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [31:0] id; logic [31:0] price; } res_t;
    typedef struct packed { logic [NE-1:0] eng; logic [167:0] pkt; } start_t;

    res_t   exp_q[$];
    res_t   got_q[$];
    start_t start_q[$];

    option_sched #(.NUM_ENG(NE), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pkt(in_pkt),
        .eng_start(eng_start), .eng_pkt(eng_pkt), .eng_done(eng_done), .eng_price(eng_price),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_price(res_price),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [167:0] mkop(input logic [31:0] id);
        return {id ^ 32'hA5A5_0000, id + 32'd100, 32'h3C23_D70A, 32'h3E4C_CCCD, id * 32'd3, id[7:0]};
    endfunction

    function automatic logic [199:0] mk(input logic [31:0] id);
        return {id, mkop(id)};
    endfunction

    // One clock: record an accept that will happen at this edge, then record any start pulse.
    task automatic step();
        if (res_valid && res_ready) got_q.push_back(res_t'({res_id, res_price}));
        @(posedge clk);
        @(negedge clk);
        if (eng_start != '0) start_q.push_back(start_t'({eng_start, eng_pkt}));
    endtask

    task automatic send(input logic [31:0] id);
        in_valid = 1'b1;
        in_pkt   = mk(id);
        step();
        in_valid = 1'b0;
    endtask

    task automatic done_eng(input int e, input logic [31:0] p);
        eng_done    = '0;
        eng_done[e] = 1'b1;
        eng_price[32*e +: 32] = p;
        step();
        eng_done = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b0; in_valid = 1'b0; eng_done = '0; res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete(); got_q.delete(); start_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (eng_start !== '0) begin errors++; $display("FAIL reset_eng_start: got %h required 0", eng_start); end
        checks++; if (eng_pkt !== '0) begin errors++; $display("FAIL reset_eng_pkt: got %h required 0", eng_pkt); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b required 0", res_valid); end
        checks++; if (res_id !== '0 || res_price !== '0) begin errors++; $display("FAIL reset_res_data: got id=%h price=%h required 0", res_id, res_price); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got overflow=%b drop_cnt=%0d required 0", overflow, drop_cnt); end
        rst = 1'b1;
        repeat (3) step();
        checks++; if (start_q.size() != 0 || res_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got starts=%0d res_valid=%b required none", start_q.size(), res_valid); end
    endtask

    task automatic test_single();
        start_t s; res_t r; res_t x;
        apply_reset();
        res_ready = 1'b1;
        send(32'h11);
        checks++; if (start_q.size() != 0) begin errors++; $display("FAIL single_latency: got start in push cycle, required later"); end
        for (int k = 0; k < 6 && start_q.size() == 0; k++) step();
        checks++;
        if (start_q.size() == 0) begin errors++; $display("FAIL single_start: got no start, required engine 0"); end
        else begin
            s = start_q.pop_front();
            if (s !== start_t'({2'b01, mkop(32'h11)})) begin errors++; $display("FAIL single_start: got %h required %h", s, start_t'({2'b01, mkop(32'h11)})); end
        end
        repeat (9) step();
        exp_q.push_back(res_t'({32'h11, 32'h4049_0FDB}));
        done_eng(0, 32'h4049_0FDB);
        for (int k = 0; k < 8 && got_q.size() == 0; k++) step();
        checks++;
        if (got_q.size() == 0) begin errors++; $display("FAIL single_res: got no result, required %h", exp_q[0]); end
        else begin
            r = got_q.pop_front(); x = exp_q.pop_front();
            if (r !== x) begin errors++; $display("FAIL single_res: got %h required %h", r, x); end
        end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_after_accept: got res_valid=%b required 0", res_valid); end
        send(32'h21);
        send(32'h22);
        for (int k = 0; k < 8 && start_q.size() < 2; k++) step();
        checks++;
        if (start_q.size() < 2) begin errors++; $display("FAIL single_free: got %0d starts, required 2 (engine 0 not freed)", start_q.size()); end
        else begin
            s = start_q.pop_front();
            if (s !== start_t'({2'b10, mkop(32'h21)})) begin errors++; $display("FAIL single_free_e1: got %h required %h", s, start_t'({2'b10, mkop(32'h21)})); end
            s = start_q.pop_front();
            if (s !== start_t'({2'b01, mkop(32'h22)})) begin errors++; $display("FAIL single_free_e0: got %h required %h", s, start_t'({2'b01, mkop(32'h22)})); end
        end
    endtask

    task automatic test_back_to_back();
        start_t s; res_t r; res_t x;
        apply_reset();
        res_ready = 1'b1;
        send(32'd1); send(32'd2); send(32'd3);
        repeat (4) step();
        checks++;
        if (start_q.size() != 2) begin errors++; $display("FAIL b2b_starts: got %0d starts, required 2", start_q.size()); end
        else begin
            s = start_q.pop_front();
            if (s !== start_t'({2'b01, mkop(32'd1)})) begin errors++; $display("FAIL b2b_id1: got %h required %h", s, start_t'({2'b01, mkop(32'd1)})); end
            s = start_q.pop_front();
            if (s !== start_t'({2'b10, mkop(32'd2)})) begin errors++; $display("FAIL b2b_id2: got %h required %h", s, start_t'({2'b10, mkop(32'd2)})); end
        end
        exp_q.push_back(res_t'({32'd1, 32'h1000_0001}));
        done_eng(0, 32'h1000_0001);
        for (int k = 0; k < 10 && (got_q.size() == 0 || start_q.size() == 0); k++) step();
        checks++;
        if (got_q.size() == 0 || start_q.size() == 0) begin errors++; $display("FAIL b2b_id3: got results=%0d starts=%0d required 1 and 1", got_q.size(), start_q.size()); end
        else begin
            r = got_q.pop_front(); x = exp_q.pop_front(); s = start_q.pop_front();
            if (r !== x) begin errors++; $display("FAIL b2b_res1: got %h required %h", r, x); end
            if (s !== start_t'({2'b01, mkop(32'd3)})) begin errors++; $display("FAIL b2b_id3_start: got %h required %h", s, start_t'({2'b01, mkop(32'd3)})); end
        end
        for (int e = 1; e >= 0; e--) begin
            exp_q.push_back(res_t'({32'd3 - 32'(e), 32'h2000_0000 + 32'(e)}));
            done_eng(e, 32'h2000_0000 + 32'(e));
            for (int k = 0; k < 8 && got_q.size() == 0; k++) step();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL b2b_drain: got no result, required %h", exp_q[0]); exp_q.delete(); end
            else begin
                r = got_q.pop_front(); x = exp_q.pop_front();
                if (r !== x) begin errors++; $display("FAIL b2b_drain: got %h required %h", r, x); end
            end
        end
    endtask

    task automatic test_same_cycle();
        res_t r; res_t x; int first_k; int second_k;
        apply_reset();
        res_ready = 1'b1;
        send(32'h31); send(32'h32);
        for (int k = 0; k < 6 && start_q.size() < 2; k++) step();
        checks++; if (start_q.size() != 2) begin errors++; $display("FAIL same_starts: got %0d starts required 2", start_q.size()); end
        start_q.delete();
        exp_q.push_back(res_t'({32'h31, 32'hAAAA_0001}));
        exp_q.push_back(res_t'({32'h32, 32'hBBBB_0002}));
        eng_price = {32'hBBBB_0002, 32'hAAAA_0001};
        eng_done  = 2'b11;
        step();
        eng_done  = '0;
        first_k = -1; second_k = -1;
        for (int k = 0; k < 10 && got_q.size() < 2; k++) begin
            step();
            if (got_q.size() >= 1 && first_k < 0) first_k = k;
            if (got_q.size() == 2 && second_k < 0) second_k = k;
        end
        checks++;
        if (got_q.size() != 2) begin errors++; $display("FAIL same_count: got %0d results required 2", got_q.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                r = got_q.pop_front(); x = exp_q.pop_front();
                if (r !== x) begin errors++; $display("FAIL same_order%0d: got %h required %h", i, r, x); end
            end
            if (second_k - first_k != 1) begin errors++; $display("FAIL same_gap: got %0d cycles between results required 1", second_k - first_k); end
        end
    endtask

    task automatic test_stall();
        start_t s; res_t r; res_t x;
        apply_reset();
        res_ready = 1'b0;
        send(32'h41);
        for (int k = 0; k < 6 && start_q.size() == 0; k++) step();
        checks++; if (start_q.size() != 1) begin errors++; $display("FAIL stall_start: got %0d starts required 1", start_q.size()); end
        start_q.delete();
        exp_q.push_back(res_t'({32'h41, 32'h1234_5678}));
        done_eng(0, 32'h1234_5678);
        for (int k = 0; k < 6 && res_valid !== 1'b1; k++) step();
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (res_valid !== 1'b1 || res_t'({res_id, res_price}) !== exp_q[0]) begin
                errors++; $display("FAIL stall_stable cycle %0d: got valid=%b %h required 1 %h", k, res_valid, res_t'({res_id, res_price}), exp_q[0]);
            end
            if (k < 2) send(32'h42 + 32'(k)); else step();
        end
        checks++;
        if (start_q.size() != 1) begin errors++; $display("FAIL stall_redispatch: got %0d starts required 1", start_q.size()); end
        else begin
            s = start_q.pop_front();
            if (s !== start_t'({2'b10, mkop(32'h42)})) begin errors++; $display("FAIL stall_e1: got %h required %h", s, start_t'({2'b10, mkop(32'h42)})); end
        end
        res_ready = 1'b1;
        for (int k = 0; k < 6 && (got_q.size() == 0 || start_q.size() == 0); k++) step();
        checks++;
        if (got_q.size() == 0 || start_q.size() == 0) begin errors++; $display("FAIL stall_release: got results=%0d starts=%0d required 1 and 1", got_q.size(), start_q.size()); end
        else begin
            r = got_q.pop_front(); x = exp_q.pop_front(); s = start_q.pop_front();
            if (r !== x) begin errors++; $display("FAIL stall_res: got %h required %h", r, x); end
            if (s !== start_t'({2'b01, mkop(32'h43)})) begin errors++; $display("FAIL stall_queued: got %h required %h", s, start_t'({2'b01, mkop(32'h43)})); end
        end
    endtask

    task automatic test_overflow();
        start_t s; res_t r; res_t x;
        apply_reset();
        res_ready = 1'b1;
        send(32'h51); send(32'h52);
        repeat (2) step();
        checks++; if (start_q.size() != 2) begin errors++; $display("FAIL ovf_busy: got %0d starts required 2", start_q.size()); end
        start_q.delete();
        for (int k = 0; k < 6; k++) send(32'h60 + 32'(k));
        checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop2: got overflow=%b drop_cnt=%0d required 1 2", overflow, drop_cnt); end
        exp_q.push_back(res_t'({32'h51, 32'h5151_5151}));
        done_eng(0, 32'h5151_5151);
        for (int k = 0; k < 8 && got_q.size() == 0; k++) step();
        checks++;
        if (got_q.size() == 0) begin errors++; $display("FAIL ovf_res: got no result required %h", exp_q[0]); end
        else begin
            r = got_q.pop_front(); x = exp_q.pop_front();
            if (r !== x) begin errors++; $display("FAIL ovf_res: got %h required %h", r, x); end
        end
        send(32'h70);
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL full_pop_push: got drop_cnt=%0d required 2", drop_cnt); end
        checks++;
        if (start_q.size() == 0) begin errors++; $display("FAIL ovf_head: got no start required %h", start_t'({2'b01, mkop(32'h60)})); end
        else begin
            s = start_q.pop_front();
            if (s !== start_t'({2'b01, mkop(32'h60)})) begin errors++; $display("FAIL ovf_head: got %h required %h", s, start_t'({2'b01, mkop(32'h60)})); end
        end
        for (int k = 0; k < 300; k++) begin
            send(32'h100 + 32'(k));
            if (k == 251) begin
                checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL drop_254: got %0d required 254", drop_cnt); end
            end
        end
        checks++; if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin errors++; $display("FAIL drop_sat: got overflow=%b drop_cnt=%0d required 1 255", overflow, drop_cnt); end
    endtask

    task automatic test_reset_midrun();
        start_t s; logic seen;
        apply_reset();
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(32'h81 + 32'(k));
        repeat (2) step();
        checks++; if (start_q.size() != 2) begin errors++; $display("FAIL mid_busy: got %0d starts required 2", start_q.size()); end
        done_eng(0, 32'hCAFE_F00D);
        repeat (2) step();
        checks++; if (res_valid !== 1'b1 || res_id !== 32'h81) begin errors++; $display("FAIL mid_pending: got valid=%b id=%h required 1 81", res_valid, res_id); end
        rst = 1'b0;
        #1;
        checks++;
        if ({eng_start, eng_pkt, res_valid, res_id, res_price, overflow, drop_cnt} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got start=%b pkt=%h valid=%b id=%h price=%h ovf=%b cnt=%0d required all 0",
                               eng_start, eng_pkt, res_valid, res_id, res_price, overflow, drop_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        start_q.delete(); got_q.delete(); exp_q.delete();
        res_ready = 1'b1;
        repeat (5) step();
        checks++; if (start_q.size() != 0) begin errors++; $display("FAIL mid_fifo_empty: got %0d starts required 0", start_q.size()); end
        eng_price = {32'hDEAD_0001, 32'hDEAD_0000};
        eng_done  = 2'b11;
        step();
        eng_done  = '0;
        seen = 1'b0;
        repeat (6) begin step(); if (res_valid !== 1'b0) seen = 1'b1; end
        checks++; if (seen || got_q.size() != 0) begin errors++; $display("FAIL mid_stale_done: got res_valid seen=%b results=%0d required none", seen, got_q.size()); end
        send(32'h91);
        for (int k = 0; k < 6 && start_q.size() == 0; k++) step();
        checks++;
        if (start_q.size() == 0) begin errors++; $display("FAIL mid_restart: got no start required %h", start_t'({2'b01, mkop(32'h91)})); end
        else begin
            s = start_q.pop_front();
            if (s !== start_t'({2'b01, mkop(32'h91)})) begin errors++; $display("FAIL mid_restart: got %h required %h", s, start_t'({2'b01, mkop(32'h91)})); end
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_pkt = '0; eng_done = '0; eng_price = '0; res_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_same_cycle();
        test_stall();
        test_overflow();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
